// File: rtl/mskaes_128bits_round_ctrl_pkg.sv
// Shared definitions for the masked AES-128 round controller: FSM encoding,
// round count, round-constant seed/reduction polynomial and counter sizing.
package mskaes_128bits_round_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_CLEAN = 2'd3
  } state_e;

  localparam int         NROUNDS   = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;

  // Bits needed for a down/up counter spanning 0..n-1 (never narrower than 1).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mskaes_rcon_gen.sv
// AES key-schedule round constant register: loads 0x01, advances by xtime.
module mskaes_rcon_gen
  import mskaes_128bits_round_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic       i_adv,
  output logic [7:0] o_rcon
);

  logic [7:0] r_rcon;
  logic [7:0] w_xtime;

  // Multiply by x in GF(2^8), reducing by the AES polynomial on overflow.
  assign w_xtime = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? RCON_POLY : 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rcon <= RCON_INIT;
    end else if (i_load) begin
      r_rcon <= RCON_INIT;
    end else if (i_adv) begin
      r_rcon <= w_xtime;
    end
  end

  assign o_rcon = r_rcon;

endmodule

// File: rtl/mskaes_128bits_round_ctrl.sv
// Round sequencer for a masked AES-128 datapath: accepts a block, paces ten
// pipelined rounds, holds the result until taken, then zeroes the pipeline.
module mskaes_128bits_round_ctrl #(
  parameter int d       = 2,
  parameter int LATENCY = 4,
  parameter int NROUNDS = mskaes_128bits_round_ctrl_pkg::NROUNDS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       sel_init,
  output logic       state_en,
  output logic       key_en,
  output logic       last_round,
  output logic       cleaning_on,
  output logic [7:0] rcon,
  output logic       busy
);

  import mskaes_128bits_round_ctrl_pkg::*;

  // Share count only matters to the datapath; reject nonsensical builds early.
  if (d < 1 || LATENCY < 1 || LATENCY > 15 || NROUNDS != 10) begin : g_bad_param
    $error("mskaes_128bits_round_ctrl: illegal parameter set");
  end

  localparam int                 LAT_W    = cnt_w(LATENCY);
  localparam int                 RND_W    = cnt_w(NROUNDS + 1);
  localparam logic [LAT_W-1:0]   LAT_MAX  = LAT_W'(LATENCY - 1);
  localparam logic [RND_W-1:0]   RND_LAST = RND_W'(NROUNDS - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [LAT_W-1:0] r_lat_cnt;
  logic [RND_W-1:0] r_round_cnt;
  logic             w_lat_zero;
  logic             w_is_last;
  logic             w_rcon_load;
  logic             w_rcon_adv;
  logic             w_en;

  assign w_lat_zero = (r_lat_cnt == '0);
  assign w_is_last  = (r_round_cnt == RND_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (in_valid)               w_state_nxt = ST_ROUND;
      ST_ROUND: if (w_lat_zero && w_is_last) w_state_nxt = ST_FINAL;
      ST_FINAL: if (out_ready)              w_state_nxt = ST_CLEAN;
      ST_CLEAN: if (w_lat_zero)             w_state_nxt = ST_IDLE;
      default:                              w_state_nxt = ST_IDLE;
    endcase
  end

  // lat_cnt paces both the round pipeline and the cleaning sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat_cnt   <= '0;
      r_round_cnt <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_lat_cnt   <= LAT_MAX;
            r_round_cnt <= '0;
          end
        end
        ST_ROUND: begin
          if (w_lat_zero) begin
            r_lat_cnt   <= LAT_MAX;
            r_round_cnt <= r_round_cnt + 1'b1;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        ST_FINAL: begin
          if (out_ready) r_lat_cnt <= LAT_MAX;
        end
        ST_CLEAN: begin
          if (!w_lat_zero) r_lat_cnt <= r_lat_cnt - 1'b1;
        end
        default: r_lat_cnt <= '0;
      endcase
    end
  end

  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    sel_init    = 1'b0;
    w_en        = 1'b0;
    last_round  = 1'b0;
    cleaning_on = 1'b0;
    busy        = 1'b1;
    w_rcon_load = 1'b0;
    w_rcon_adv  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        busy        = 1'b0;
        in_ready    = 1'b1;
        sel_init    = in_valid;
        w_en        = in_valid;
        w_rcon_load = in_valid;
      end
      ST_ROUND: begin
        last_round = w_is_last;
        w_en       = w_lat_zero;
        // rcon stays on the final constant once the last round has been issued.
        w_rcon_adv = w_lat_zero && !w_is_last;
      end
      ST_FINAL: begin
        out_valid = 1'b1;
      end
      ST_CLEAN: begin
        cleaning_on = 1'b1;
        w_en        = w_lat_zero;
      end
      default: busy = 1'b0;
    endcase
  end

  assign state_en = w_en;
  assign key_en   = w_en;

  mskaes_rcon_gen u_rcon_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_rcon_load),
    .i_adv  (w_rcon_adv),
    .o_rcon (rcon)
  );

endmodule

// File: tb/tb_mskaes_128bits_round_ctrl.sv
// Randomized scoreboard bench for the AES-128 round controller.
module tb_mskaes_128bits_round_ctrl;

  localparam int L  = 4;
  localparam int NR = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic       sel_init;
  logic       state_en;
  logic       key_en;
  logic       last_round;
  logic       cleaning_on;
  logic [7:0] rcon;
  logic       busy;

  always #5 clk = ~clk;

  mskaes_128bits_round_ctrl #(.d(2), .LATENCY(L), .NROUNDS(NR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sel_init    (sel_init),
    .state_en    (state_en),
    .key_en      (key_en),
    .last_round  (last_round),
    .cleaning_on (cleaning_on),
    .rcon        (rcon),
    .busy        (busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int exp_q[$];
  int rc[NR];
  int blocks_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, req);
    end
  endtask

  // Round constants: repeated doubling in GF(2^8) modulo x^8+x^4+x^3+x+1.
  initial begin
    int v;
    v = 1;
    for (int i = 0; i < NR; i++) begin
      rc[i] = v;
      v = v * 2;
      if (v > 255) v = v ^ 'h11B;
    end
  end

  // Reference model: block timeline derived from the accept and handshake cycles.
  int m_mode = 0;
  int m_acc  = 0;
  int m_hs   = 0;
  bit m_seen = 0;

  always @(negedge clk) begin
    int t, k;
    bit p;
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_state_en", state_en, 0);
      chk("rst_cleaning", cleaning_on, 0);
      chk("rst_rcon", rcon, 8'h01);
      m_mode = 0;
    end else if (m_mode == 0) begin
      chk("idle_in_ready", in_ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_cleaning", cleaning_on, 0);
      chk("idle_last_round", last_round, 0);
      chk("accept_sel_init", sel_init, in_valid);
      chk("accept_state_en", state_en, in_valid);
      chk("accept_key_en", key_en, in_valid);
      if (in_valid) begin
        m_mode = 1;
        m_acc  = cyc;
        m_seen = 0;
      end
    end else if (m_mode == 1) begin
      t = cyc - m_acc;
      chk("run_in_ready", in_ready, 0);
      chk("run_busy", busy, 1);
      chk("run_cleaning", cleaning_on, 0);
      chk("run_sel_init", sel_init, 0);
      if (t <= NR * L) begin
        k = (t - 1) / L;
        p = ((t - 1) % L) == (L - 1);
        chk("round_out_valid", out_valid, 0);
        chk("round_last_round", last_round, (k == NR - 1));
        chk("round_state_en", state_en, p);
        chk("round_key_en", key_en, p);
        if (p) chk("round_rcon", rcon, rc[k]);
      end else begin
        chk("final_out_valid", out_valid, 1);
        chk("final_state_en", state_en, 0);
        chk("final_key_en", key_en, 0);
        chk("final_last_round", last_round, 0);
        if (!m_seen) begin
          m_seen = 1;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_out_valid cycle=%0d got=out_valid expected=no pending block", cyc);
          end else begin
            chk("out_valid_cycle", cyc, exp_q.pop_front());
          end
        end
        if (out_ready) begin
          m_mode = 2;
          m_hs   = cyc;
        end
      end
    end else begin
      chk("clean_cleaning", cleaning_on, 1);
      chk("clean_in_ready", in_ready, 0);
      chk("clean_out_valid", out_valid, 0);
      chk("clean_busy", busy, 1);
      chk("clean_state_en", state_en, (cyc == m_hs + L));
      chk("clean_key_en", key_en, (cyc == m_hs + L));
      if (cyc == m_hs + L) m_mode = 0;
    end
  end

  // Stimulus: random valid/ready traffic, a 7-cycle FINAL stall on the first
  // block, a mid-block reset, then a run of back-to-back blocks.
  initial begin
    int  target;
    int  stall_left;
    int  last_acc;
    bit  rst_done;
    bit  force_iv;
    target     = 8;
    stall_left = 7;
    last_acc   = -1000;
    rst_done   = 0;
    force_iv   = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 4000 && blocks_done < target; n++) begin
      @(posedge clk);
      #1;
      if (!rst_done && blocks_done == 2 && busy && cyc == last_acc + 20) begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_state_en", state_en, 0);
        chk("async_rst_rcon", rcon, 8'h01);
        chk("async_rst_last_round", last_round, 0);
        exp_q.delete();
        rst_done = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        force_iv = 1;
      end
      if (force_iv || (blocks_done >= 4 && blocks_done < 7)) in_valid = 1'b1;
      else in_valid = ($urandom % 3) == 0;
      force_iv = 0;
      if (out_valid) begin
        out_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end else begin
        out_ready  = $urandom % 2;
        stall_left = (blocks_done == 0) ? 7 : int'($urandom % 4);
      end
      if (out_valid && out_ready) blocks_done++;
      if (in_valid && in_ready) begin
        exp_q.push_back(cyc + 1 + NR * L);
        last_acc = cyc;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (NR * L + 3 * L + 10) @(posedge clk);
    #1;
    chk("blocks_completed", (blocks_done >= target), 1);
    chk("queue_drained", exp_q.size(), 0);
    chk("idle_at_end", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
